// File: rtl/alu_ctrl_defs.sv
// Shared definitions for the nibble-serial add/subtract controller.
// Holds the FSM encoding and the pass-counter width.
package alu_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for the largest legal operand (32 bits -> 8 passes, cnt 0..7).
  localparam int NIB_W = 3;

endpackage

// File: rtl/rcadder.sv
// 4-bit ripple-carry adder: the only arithmetic element of the serial ALU.
// Built as a chain of full adders.
module rcadder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] carry;

  assign carry[0] = Cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign Sum[gi]       = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign Cout = carry[4];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial add/subtract unit: one 4-bit adder processes the operands
// over NIB passes; results appear only when the final pass completes.
module nibble_serial_alu_ctrl
  import alu_ctrl_defs::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int IW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [NIB_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
  logic [WIDTH-1:0] sum_reg;
  logic             sub_reg, carry_reg, cout_reg, ovf_reg;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cout;
  logic [IW-1:0]    idx;
  logic             accept, last_pass;

  assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_pass = (state_reg == RUN) && (cnt_reg == NIB_W'(NIB - 1));

  // Operands shift right each pass, so the current nibble is always at [3:0].
  assign add_a = a_reg[3:0];
  assign add_b = b_reg[3:0] ^ {4{sub_reg}};
  assign idx   = IW'({cnt_reg, 2'b00});

  rcadder u_rcadder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_reg),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    res_next             = res_reg;
    res_next[idx +: 4]   = add_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_pass) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      sub_reg   <= sub;
      cnt_reg   <= '0;
      carry_reg <= sub;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> 4;
      b_reg     <= b_reg >> 4;
      res_reg   <= res_next;
      carry_reg <= add_cout;
      cnt_reg   <= last_pass ? '0 : cnt_reg + NIB_W'(1);
      // Visible outputs change only here, so partial sums never leak out.
      if (last_pass) begin
        sum_reg  <= res_next;
        cout_reg <= add_cout;
        ovf_reg  <= (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);
      end
    end
  end

  assign Sum  = sum_reg;
  assign Cout = cout_reg;
  assign Ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench for nibble_serial_alu_ctrl (WIDTH=16): scoreboard of
// expected results pushed at start acceptance, popped when done pulses.
module tb_nibble_serial_alu_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int LAT   = NIB + 1;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [15:0] A, B;
  logic        busy, done, Cout, Ovf;
  logic [15:0] Sum;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] last_sum = '0;

  always #5 clk = ~clk;

  nibble_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    res_t        r;
    logic [15:0] beff;
    logic [16:0] t;
    beff   = s ? ~b : b;
    t      = {1'b0, a} + {1'b0, beff} + {16'd0, s};
    r.sum  = t[15:0];
    r.cout = t[16];
    r.ovf  = (a[15] == beff[15]) && (r.sum[15] != a[15]);
    return r;
  endfunction

  task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    A     = a;
    B     = b;
    sub   = s;
    start = 1'b1;
    exp_q.push_back(model(a, b, s));
  endtask

  // Advance on negedges until done is seen or the cycle budget runs out.
  task automatic wait_done(inout int cyc);
    while (done !== 1'b1 && cyc < 4 * LAT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One complete operation starting from IDLE; caller is at a negedge.
  task automatic test_single(input logic [15:0] a, input logic [15:0] b, input logic s,
                             input string name);
    res_t e;
    int   cyc;
    push_op(a, b, s);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
    @(negedge clk);
    cyc++;
    n_checks++;
    if (Sum !== last_sum) begin
      n_fail++;
      $display("FAIL %s_hold: Sum=%h mid-run, required previous %h", name, Sum, last_sum);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc != LAT) begin
      n_fail++;
      $display("FAIL %s_latency: done at cycle %0d, required %0d", name, cyc, LAT);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if ({Sum, Cout, Ovf} !== {e.sum, e.cout, e.ovf} || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_result: Sum=%h Cout=%b Ovf=%b busy=%b, required Sum=%h Cout=%b Ovf=%b busy=0",
               name, Sum, Cout, Ovf, busy, e.sum, e.cout, e.ovf);
    end
    $display("op %s: A=%h B=%h sub=%b -> Sum=%h Cout=%b Ovf=%b (cycle %0d)",
             name, a, b, s, Sum, Cout, Ovf, cyc);
    last_sum = e.sum;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: done=%b busy=%b after done, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    A     = 16'hAAAA;
    B     = 16'h5555;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, Sum, Cout, Ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b Sum=%h Cout=%b Ovf=%b, required all 0",
               busy, done, Sum, Cout, Ovf);
    end
    $display("reset: busy=%b done=%b Sum=%h Cout=%b Ovf=%b", busy, done, Sum, Cout, Ovf);
    rst = 1'b0;
    test_single(16'h1234, 16'h4321, 1'b0, "first_after_reset");
  endtask

  task automatic test_vectors();
    test_single(16'hFFFF, 16'h0001, 1'b0, "carry_wrap");
    test_single(16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
    test_single(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    test_single(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    test_single(16'h0007, 16'h0005, 1'b1, "sub_noborrow");
    for (int i = 0; i < 4; i++) begin
      test_single(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_ignore_start();
    res_t e;
    int   cyc;
    int   extra;
    push_op(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A     = 16'hABCD;
    B     = 16'h1357;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 3;
    wait_done(cyc);
    n_checks++;
    if (cyc != LAT) begin
      n_fail++;
      $display("FAIL ignore_latency: done at cycle %0d, required %0d", cyc, LAT);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if ({Sum, Cout, Ovf} !== {e.sum, e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL ignore_result: Sum=%h Cout=%b Ovf=%b, required Sum=%h Cout=%b Ovf=%b",
               Sum, Cout, Ovf, e.sum, e.cout, e.ovf);
    end
    $display("op ignore_start: Sum=%h Cout=%b Ovf=%b", Sum, Cout, Ovf);
    last_sum = e.sum;
    extra = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignore_queued: %0d busy/done cycles after op, required 0", extra);
    end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    push_op(16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, Sum, Cout, Ovf} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b Sum=%h Cout=%b Ovf=%b, required all 0",
               busy, done, Sum, Cout, Ovf);
    end
    $display("op midrun_reset: aborted, busy=%b Sum=%h", busy, Sum);
    rst = 1'b0;
    void'(exp_q.pop_front());
    last_sum = '0;
    pulses   = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midrun_done: %0d done pulses after abort, required 0", pulses);
    end
    test_single(16'h0F0F, 16'h0101, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops_a[4] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h0003};
    logic [15:0] ops_b[4] = '{16'h0234, 16'hFFFF, 16'hFFFF, 16'h0009};
    logic        ops_s[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    res_t        e;
    int          cyc;
    push_op(ops_a[0], ops_b[0], ops_s[0]);
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc);
      n_checks++;
      if (cyc != LAT) begin
        n_fail++;
        $display("FAIL b2b_period[%0d]: done after %0d cycles, required %0d", i, cyc, LAT);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_checks++;
      if ({Sum, Cout, Ovf} !== {e.sum, e.cout, e.ovf}) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: Sum=%h Cout=%b Ovf=%b, required Sum=%h Cout=%b Ovf=%b",
                 i, Sum, Cout, Ovf, e.sum, e.cout, e.ovf);
      end
      $display("op b2b[%0d]: A=%h B=%h sub=%b -> Sum=%h Cout=%b Ovf=%b",
               i, ops_a[i], ops_b[i], ops_s[i], Sum, Cout, Ovf);
      if (i < 3) push_op(ops_a[i + 1], ops_b[i + 1], ops_s[i + 1]);
      else start = 1'b0;
      @(negedge clk);
      cyc = 1;
      n_checks++;
      if (busy !== (i < 3) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: busy=%b done=%b, required busy=%b done=0",
                 i, busy, done, (i < 3));
      end
    end
    last_sum = e.sum;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
